// File: rtl/jk_excite_if.sv
// Target handshake between a producer and the JK excitation driver.
interface jk_excite_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_target;

    modport master (
        output in_valid,
        output in_target,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_target,
        output in_ready
    );
endinterface

// File: rtl/jk_excite_driver.sv
// Queues desired next states for an external JK flip-flop bank, drives the
// J/K excitation for each one, then checks that the bank reached the target.
module jk_excite_driver #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DC_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    jk_excite_if.slave       in_if,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             chk_valid,
    output logic             chk_ok,
    input  logic             clear_err,
    output logic             err_sticky,
    output logic [7:0]       err_count,
    output logic             busy
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] DC_VEC = {WIDTH{DC_VALUE != 0}};
    localparam logic [7:0] ERR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   expected;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               issue;
    logic               match;
    logic               mismatch;
    logic [WIDTH-1:0]   head;
    logic [WIDTH-1:0]   j_exc;
    logic [WIDTH-1:0]   k_exc;

    // FIFO status and handshake; ready is forced high while in reset
    assign fifo_full      = (count == CNT_W'(DEPTH));
    assign fifo_empty     = (count == '0);
    assign in_if.in_ready = reset | ~fifo_full;
    assign push           = in_if.in_valid & ~fifo_full & ~reset;
    assign head           = mem[rd_ptr];

    // A new target issues from IDLE or from CHECK whenever one is queued
    assign issue = ~reset & ~fifo_empty & ((state == IDLE) | (state == CHECK));

    // Per-bit JK excitation from current Q to the head target
    assign j_exc = (~q_fb & head) | (q_fb & DC_VEC);
    assign k_exc = (~q_fb & DC_VEC) | (q_fb & ~head);

    // Check result is presented combinationally for the whole CHECK cycle
    assign match     = (q_fb == expected);
    assign chk_valid = ~reset & (state == CHECK);
    assign chk_ok    = chk_valid & match;
    assign mismatch  = chk_valid & ~match;

    assign busy = ~reset & ((state != IDLE) | ~fifo_empty);

    // Target storage; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_if.in_target;
        end
    end

    // FIFO pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer: issue -> drive one cycle -> check, J/K held at zero otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            j_out    <= '0;
            k_out    <= '0;
            expected <= '0;
        end else begin
            case (state)
                IDLE, CHECK: begin
                    if (issue) begin
                        j_out    <= j_exc;
                        k_out    <= k_exc;
                        expected <= head;
                        state    <= DRIVE;
                    end else begin
                        j_out <= '0;
                        k_out <= '0;
                        state <= IDLE;
                    end
                end
                DRIVE: begin
                    j_out <= '0;
                    k_out <= '0;
                    state <= CHECK;
                end
                default: begin
                    j_out <= '0;
                    k_out <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Error tracking; a mismatch wins over a coincident clear but restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (mismatch) begin
            err_sticky <= 1'b1;
            if (clear_err) begin
                err_count <= 8'd1;
            end else if (err_count != ERR_MAX) begin
                err_count <= err_count + 8'd1;
            end
        end else if (clear_err) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end
    end
endmodule
